// File: rtl/layer_train_sequencer_pkg.sv
// Shared types for the layer training sequencer: value encodings, state enum
// and timer sizing helper.
package layer_train_sequencer_pkg;

    typedef logic [7:0]         zero2one_t;
    typedef logic signed [15:0] frac_t;

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        FWD,
        LRN,
        EMIT,
        DONE
    } seq_state_t;

    // Timer must hold the larger of the two latencies.
    function automatic int lat_width(int a, int b);
        int mx;
        mx = (a > b) ? a : b;
        return (mx < 2) ? 1 : $clog2(mx + 1);
    endfunction

endpackage

// File: rtl/layer_train_sequencer_if.sv
// Sample and result valid/ready streams between the sample source and the
// layer training sequencer.
interface layer_train_sequencer_if
    import layer_train_sequencer_pkg::*;
#(
    parameter int N = 16,
    parameter int M = 49
) ();

    logic                  s_valid;
    logic                  s_ready;
    zero2one_t [N-1:0]     s_in;
    zero2one_t [M-1:0]     s_expected;
    logic                  m_valid;
    logic                  m_ready;
    zero2one_t [M-1:0]     m_out;

    modport master (
        output s_valid, s_in, s_expected, m_ready,
        input  s_ready, m_valid, m_out
    );

    modport slave (
        input  s_valid, s_in, s_expected, m_ready,
        output s_ready, m_valid, m_out
    );

endinterface

// File: rtl/layer_train_sequencer_lat_timer.sv
// Loadable down-counter; expire is high in the last cycle of the loaded wait.
module lat_timer #(
    parameter int W = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expire = (cnt == W'(1));

endmodule

// File: rtl/layer_train_sequencer.sv
// Drives one fully-connected layer through forward/learn passes per sample and
// returns the forward outputs, counting samples per epoch and epochs per run.
//
//  state  | meaning
//  IDLE   | waiting for start
//  ACCEPT | s_ready high, waiting for a sample
//  FWD    | layer_valid pulsed, waiting FWD_LAT cycles, then capture layer_out
//  LRN    | layer_learn pulsed, waiting LRN_LAT cycles
//  EMIT   | m_valid high until m_ready, then advance counters
//  DONE   | one-cycle done pulse
module layer_train_sequencer
    import layer_train_sequencer_pkg::*;
#(
    parameter int N       = 16,
    parameter int M       = 49,
    parameter int FWD_LAT = 1,
    parameter int LRN_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              train_en,
    input  logic [CNT_W-1:0]  num_samples,
    input  logic [CNT_W-1:0]  num_epochs,
    layer_train_sequencer_if.slave bus,
    output logic              layer_valid,
    output logic              layer_learn,
    output zero2one_t [N-1:0] layer_in,
    output zero2one_t [M-1:0] layer_expected_out,
    input  zero2one_t [M-1:0] layer_out,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sample_idx,
    output logic [CNT_W-1:0]  epoch_idx
);

    localparam int TW = lat_width(FWD_LAT, LRN_LAT);

    seq_state_t        state;
    logic              train_l;
    logic [CNT_W-1:0]  last_sample;
    logic [CNT_W-1:0]  last_epoch;
    logic              tmr_load;
    logic [TW-1:0]     tmr_val;
    logic              tmr_expire;

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (state == ACCEPT && bus.s_valid && bus.s_ready) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(FWD_LAT);
        end else if (state == FWD && tmr_expire) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(LRN_LAT);
        end
    end

    lat_timer #(.W(TW)) u_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            train_l            <= 1'b0;
            last_sample        <= '0;
            last_epoch         <= '0;
            bus.s_ready        <= 1'b0;
            bus.m_valid        <= 1'b0;
            bus.m_out          <= '0;
            layer_valid        <= 1'b0;
            layer_learn        <= 1'b0;
            layer_in           <= '0;
            layer_expected_out <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            sample_idx         <= '0;
            epoch_idx          <= '0;
        end else if (abort) begin
            // Counters and layer vectors are left as they are for post-mortem.
            state       <= IDLE;
            bus.s_ready <= 1'b0;
            bus.m_valid <= 1'b0;
            layer_valid <= 1'b0;
            layer_learn <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        train_l     <= train_en;
                        last_sample <= (num_samples == '0) ? '0 : num_samples - CNT_W'(1);
                        last_epoch  <= (num_epochs == '0) ? '0 : num_epochs - CNT_W'(1);
                        sample_idx  <= '0;
                        epoch_idx   <= '0;
                        busy        <= 1'b1;
                        bus.s_ready <= 1'b1;
                        state       <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (bus.s_valid && bus.s_ready) begin
                        layer_in           <= bus.s_in;
                        layer_expected_out <= bus.s_expected;
                        bus.s_ready        <= 1'b0;
                        layer_valid        <= 1'b1;
                        state              <= FWD;
                    end
                end
                FWD: begin
                    layer_valid <= 1'b0;
                    if (tmr_expire) begin
                        bus.m_out <= layer_out;
                        if (train_l) begin
                            layer_learn <= 1'b1;
                            state       <= LRN;
                        end else begin
                            bus.m_valid <= 1'b1;
                            state       <= EMIT;
                        end
                    end
                end
                LRN: begin
                    layer_learn <= 1'b0;
                    if (tmr_expire) begin
                        bus.m_valid <= 1'b1;
                        state       <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.m_ready) begin
                        bus.m_valid <= 1'b0;
                        if (sample_idx == last_sample) begin
                            sample_idx <= '0;
                            epoch_idx  <= epoch_idx + CNT_W'(1);
                            if (epoch_idx == last_epoch) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                bus.s_ready <= 1'b1;
                                state       <= ACCEPT;
                            end
                        end else begin
                            sample_idx  <= sample_idx + CNT_W'(1);
                            bus.s_ready <= 1'b1;
                            state       <= ACCEPT;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_train_sequencer.sv
// Randomized scoreboard bench for layer_train_sequencer with a behavioural
// layer model that only presents the true forward result in the capture cycle.
module tb_layer_train_sequencer;
    import layer_train_sequencer_pkg::*;

    localparam int N       = 16;
    localparam int M       = 49;
    localparam int FWD_LAT = 2;
    localparam int LRN_LAT = 3;
    localparam int CNT_W   = 16;

    typedef zero2one_t [N-1:0] nvec_t;
    typedef zero2one_t [M-1:0] mvec_t;
    typedef struct {
        mvec_t out;
        nvec_t in;
        mvec_t exp;
        int    s;
        int    e;
    } sb_t;

    sb_t sb[$];

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             train_en = 1'b0;
    logic [CNT_W-1:0] num_samples = '0;
    logic [CNT_W-1:0] num_epochs = '0;
    logic             layer_valid, layer_learn, busy, done;
    nvec_t            layer_in;
    mvec_t            layer_expected_out;
    mvec_t            layer_out;
    logic [CNT_W-1:0] sample_idx, epoch_idx;

    layer_train_sequencer_if #(.N(N), .M(M)) bus ();

    layer_train_sequencer #(
        .N(N), .M(M), .FWD_LAT(FWD_LAT), .LRN_LAT(LRN_LAT), .CNT_W(CNT_W)
    ) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .start              (start),
        .abort              (abort),
        .train_en           (train_en),
        .num_samples        (num_samples),
        .num_epochs         (num_epochs),
        .bus                (bus.slave),
        .layer_valid        (layer_valid),
        .layer_learn        (layer_learn),
        .layer_in           (layer_in),
        .layer_expected_out (layer_expected_out),
        .layer_out          (layer_out),
        .busy               (busy),
        .done               (done),
        .sample_idx         (sample_idx),
        .epoch_idx          (epoch_idx)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    task automatic chk(string nm, logic [511:0] act, logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic nvec_t rand_n();
        nvec_t v;
        for (int i = 0; i < N; i++) v[i] = zero2one_t'($urandom_range(0, 255));
        return v;
    endfunction

    function automatic mvec_t rand_m();
        mvec_t v;
        for (int i = 0; i < M; i++) v[i] = zero2one_t'($urandom_range(0, 255));
        return v;
    endfunction

    // Stand-in for the neuron layer's forward function.
    function automatic mvec_t layer_fn(nvec_t x, mvec_t t);
        mvec_t r;
        for (int j = 0; j < M; j++) r[j] = zero2one_t'(int'(x[j % N]) + int'(t[j]) + j);
        return r;
    endfunction

    // Layer model: its output is valid only FWD_LAT-1 cycles after the valid pulse.
    int fwd_cnt = -1;
    always @(posedge clock) begin
        #1;
        if (layer_valid) fwd_cnt = FWD_LAT - 1;
        else if (fwd_cnt >= 0) fwd_cnt--;
        if (fwd_cnt == 0) layer_out = layer_fn(layer_in, layer_expected_out);
        else layer_out = rand_m();
    end

    int m_mode = 0;
    int hold = 0;
    always @(posedge clock) begin
        #1;
        case (m_mode)
            0: bus.m_ready = 1'b1;
            1: bus.m_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (bus.m_valid) hold++;
                else hold = 0;
                bus.m_ready = (hold >= 6);
            end
        endcase
    end

    int    cyc = 0;
    int    lv_cnt = 0, ln_cnt = 0, res_cnt = 0, done_cnt = 0;
    int    lv_cyc = -100, ln_cyc = -100;
    logic  prev_lv = 1'b0, prev_mv = 1'b0, prev_mr = 1'b0, prev_abort = 1'b0;
    mvec_t prev_mout;
    logic  cur_train = 1'b0;
    sb_t   mon_x;

    always @(negedge clock) begin
        cyc++;
        if (reset_n) begin
            if (layer_valid) begin
                chk("lv_width", 512'(prev_lv), 512'(0));
                lv_cnt++;
                lv_cyc = cyc;
            end
            if (layer_learn) begin
                chk("learn_delay", 512'(cyc - lv_cyc), 512'(FWD_LAT));
                ln_cnt++;
                ln_cyc = cyc;
            end
            if (bus.m_valid && !prev_mv)
                chk("mvalid_delay", 512'(cyc), 512'(cur_train ? ln_cyc + LRN_LAT : lv_cyc + FWD_LAT));
            if (prev_mv && !prev_mr && !prev_abort) begin
                chk("stall_ctrl", 512'({bus.m_valid, bus.s_ready, layer_valid}), 512'(3'b100));
                chk("stall_m_out", 512'(bus.m_out), 512'(prev_mout));
            end
            if (bus.m_valid && bus.m_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 512'(sb.size()), 512'(1));
                end else begin
                    mon_x = sb.pop_front();
                    chk("m_out", 512'(bus.m_out), 512'(mon_x.out));
                    chk("idx", 512'({sample_idx, epoch_idx}), 512'({CNT_W'(mon_x.s), CNT_W'(mon_x.e)}));
                    chk("hold_in", 512'(layer_in), 512'(mon_x.in));
                    chk("hold_exp", 512'(layer_expected_out), 512'(mon_x.exp));
                    res_cnt++;
                end
            end
            if (done) done_cnt++;
        end
        prev_lv    = layer_valid;
        prev_mv    = bus.m_valid;
        prev_mr    = bus.m_ready;
        prev_abort = abort;
        prev_mout  = bus.m_out;
    end

    task automatic start_run(bit t, int ns, int ne);
        @(posedge clock); #1;
        train_en    = t;
        num_samples = CNT_W'(ns);
        num_epochs  = CNT_W'(ne);
        start       = 1'b1;
        @(posedge clock); #1;
        start       = 1'b0;
        train_en    = ~t;
        num_samples = CNT_W'($urandom_range(0, 9));
        num_epochs  = CNT_W'($urandom_range(0, 9));
    endtask

    task automatic pulse_start(bit t, int ns, int ne);
        @(posedge clock); #1;
        train_en    = t;
        num_samples = CNT_W'(ns);
        num_epochs  = CNT_W'(ne);
        start       = 1'b1;
        @(posedge clock); #1;
        start       = 1'b0;
    endtask

    task automatic send_sample(int s, int e);
        sb_t x;
        int  n;
        x.in  = rand_n();
        x.exp = rand_m();
        x.out = layer_fn(x.in, x.exp);
        x.s   = s;
        x.e   = e;
        @(posedge clock); #1;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clock); #1;
        end
        sb.push_back(x);
        bus.s_in       = x.in;
        bus.s_expected = x.exp;
        bus.s_valid    = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!bus.s_ready && n < 400);
        chk("accept_timeout", 512'(bus.s_ready), 512'(1));
        @(posedge clock); #1;
        bus.s_valid    = 1'b0;
        bus.s_in       = rand_n();
        bus.s_expected = rand_m();
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!done && n < 400);
        chk("done_timeout", 512'(done), 512'(1));
        chk("done_busy", 512'(busy), 512'(0));
        chk("sb_left", 512'(sb.size()), 512'(0));
    endtask

    task automatic run(bit t, int ns, int ne, int mode, bit poke);
        int nse, nee;
        nse = (ns == 0) ? 1 : ns;
        nee = (ne == 0) ? 1 : ne;
        lv_cnt = 0; ln_cnt = 0; res_cnt = 0; done_cnt = 0;
        m_mode = mode;
        cur_train = t;
        start_run(t, ns, ne);
        for (int e = 0; e < nee; e++) begin
            for (int s = 0; s < nse; s++) begin
                if (poke && e == 0 && s == 1) pulse_start(~t, 7, 5);
                send_sample(s, e);
            end
        end
        wait_done();
        @(posedge clock); #1;
        chk("n_valid", 512'(lv_cnt), 512'(nse * nee));
        chk("n_learn", 512'(ln_cnt), 512'(t ? nse * nee : 0));
        chk("n_result", 512'(res_cnt), 512'(nse * nee));
        chk("n_done", 512'(done_cnt), 512'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int    n;
        nvec_t kept_in;
        bus.s_valid    = 1'b0;
        bus.s_in       = '0;
        bus.s_expected = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_ctrl", 512'({bus.s_ready, bus.m_valid, layer_valid, layer_learn, busy, done}), 512'(0));
        chk("rst_idx", 512'({sample_idx, epoch_idx}), 512'(0));
        chk("rst_m_out", 512'(bus.m_out), 512'(0));
        chk("rst_layer_in", 512'(layer_in), 512'(0));
        chk("rst_layer_exp", 512'(layer_expected_out), 512'(0));
        @(posedge clock); #1;
        reset_n = 1'b1;

        run(1'b0, 3, 1, 0, 1'b0);
        run(1'b1, 2, 1, 0, 1'b0);
        run(1'b1, 2, 2, 1, 1'b1);
        run(1'b0, 2, 1, 2, 1'b0);
        run(1'b1, 0, 0, 1, 1'b0);

        // Reset while a result is waiting in EMIT.
        m_mode = 2;
        cur_train = 1'b1;
        start_run(1'b1, 2, 1);
        send_sample(0, 0);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!bus.m_valid && n < 100);
        chk("emit_reached", 512'(bus.m_valid), 512'(1));
        @(posedge clock); #1;
        reset_n = 1'b0;
        @(negedge clock);
        chk("rstmid_ctrl", 512'({bus.s_ready, bus.m_valid, layer_valid, layer_learn, busy, done}), 512'(0));
        chk("rstmid_m_out", 512'(bus.m_out), 512'(0));
        chk("rstmid_layer_in", 512'(layer_in), 512'(0));
        @(posedge clock); #1;
        reset_n = 1'b1;
        sb.delete();
        run(1'b1, 2, 1, 0, 1'b0);

        // Abort during the learn wait of the second sample.
        m_mode = 0;
        cur_train = 1'b1;
        done_cnt = 0;
        start_run(1'b1, 3, 1);
        send_sample(0, 0);
        send_sample(1, 0);
        kept_in = sb[sb.size() - 1].in;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!layer_learn && n < 100);
        chk("learn_reached", 512'(layer_learn), 512'(1));
        @(posedge clock); #1;
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        @(negedge clock);
        chk("abort_ctrl", 512'({busy, layer_learn, layer_valid, bus.m_valid, bus.s_ready, done}), 512'(0));
        chk("abort_keep_idx", 512'(sample_idx), 512'(1));
        chk("abort_keep_in", 512'(layer_in), 512'(kept_in));
        repeat (10) @(negedge clock);
        chk("abort_no_done", 512'(done_cnt), 512'(0));
        sb.delete();
        run(1'b0, 1, 1, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
